// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and its datapath/memories.
// The slave side is the controller; the master side drives instruction fields and memory status.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        aluZero;
    logic        imemReady;
    logic        dmemReady;
    logic        pcWrite;
    logic        pcSrc;
    logic        irWrite;
    logic        regwrite;
    logic        memRead;
    logic        memWrite;
    logic        memtoReg;
    logic        aluSrc;
    logic [1:0]  aluOp;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] instret;

    modport master (
        output opcode, funct3, aluZero, imemReady, dmemReady,
        input  pcWrite, pcSrc, irWrite, regwrite, memRead, memWrite,
        input  memtoReg, aluSrc, aluOp, state, halted, instret
    );

    modport slave (
        input  opcode, funct3, aluZero, imemReady, dmemReady,
        output pcWrite, pcSrc, irWrite, regwrite, memRead, memWrite,
        output memtoReg, aluSrc, aluOp, state, halted, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT
// with a retired-instruction counter that steps on the single pcWrite of each instruction.
module multicycle_control (
    input logic                  clock,
    input logic                  reset,
    multicycle_control_if.slave  bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic       pc_write, pc_src, ir_write, reg_write;
    logic       mem_read, mem_write, memto_reg, alu_src, halted;
    logic [1:0] alu_op;

    logic is_r, is_i, is_load, is_store, is_br, legal;

    assign is_r     = (bus.opcode == OP_R);
    assign is_i     = (bus.opcode == OP_I);
    assign is_load  = (bus.opcode == OP_LOAD);
    assign is_store = (bus.opcode == OP_STORE);
    // Only beq (000) and bne (001) are supported branches.
    assign is_br    = (bus.opcode == OP_BRANCH) && (bus.funct3[2:1] == 2'b00);
    assign legal    = is_r | is_i | is_load | is_store | is_br;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Handshake: imemReady high in FETCH means the instruction word is valid this cycle
    // and is captured with irWrite; in MEMORY the request is held until dmemReady is high.
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        memto_reg = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = bus.imemReady;
                if (bus.imemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                alu_src = is_i | is_load | is_store;
                if (is_br)      alu_op = 2'b01;
                else if (is_r)  alu_op = 2'b10;
                else if (is_i)  alu_op = 2'b11;
                else            alu_op = 2'b00;
                if (is_br) begin
                    pc_write = 1'b1;
                    pc_src   = bus.funct3[0] ? ~bus.aluZero : bus.aluZero;
                    state_d  = S_FETCH;
                end else if (is_r | is_i) begin
                    state_d = S_WRITEBACK;
                end else if (is_load | is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEMORY: begin
                alu_src   = 1'b1;
                alu_op    = 2'b00;
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.dmemReady) begin
                    if (is_load) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                memto_reg = is_load;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Every instruction retires on its one pcWrite cycle.
    assign instret_d = instret_q + {31'd0, pc_write};

    assign bus.pcWrite  = pc_write  & ~reset;
    assign bus.irWrite  = ir_write  & ~reset;
    assign bus.regwrite = reg_write & ~reset;
    assign bus.memRead  = mem_read  & ~reset;
    assign bus.memWrite = mem_write & ~reset;
    assign bus.pcSrc    = pc_src;
    assign bus.memtoReg = memto_reg;
    assign bus.aluSrc   = alu_src;
    assign bus.aluOp    = alu_op;
    assign bus.halted   = halted;
    assign bus.state    = state_q;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction scenario
// cycle by cycle and compares against hand-derived state/strobe sequences.
module tb_multicycle_control;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input logic im, input logic dm);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.aluZero   = z;
        bus.imemReady = im;
        bus.dmemReady = dm;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (bus.state !== 3'd0 || bus.instret !== 32'd0) begin
            $display("FAIL reset_state: state=%0d instret=%0h, want 0/0", bus.state, bus.instret);
            miscompares++;
        end
        vectors++;
        if ({bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite} !== 5'b0) begin
            $display("FAIL reset_strobes: strobes=%b, want 00000",
                     {bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite});
            miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.state !== 3'd0 || bus.irWrite !== 1'b1) begin
            $display("FAIL reset_release: state=%0d irWrite=%b, want 0/1", bus.state, bus.irWrite);
            miscompares++;
        end
    endtask

    task automatic test_r_type();
        logic [2:0]  exp_st [4];
        logic [31:0] start;
        int          pc_cnt;
        exp_st[0] = 3'd0; exp_st[1] = 3'd1; exp_st[2] = 3'd2; exp_st[3] = 3'd4;
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
        start  = bus.instret;
        pc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.state !== exp_st[i] || bus.regwrite !== (i == 3)) begin
                $display("FAIL r_cycle%0d: state=%0d regwrite=%b, want %0d/%b",
                         i, bus.state, bus.regwrite, exp_st[i], (i == 3));
                miscompares++;
            end
            if (i == 2) begin
                vectors++;
                if (bus.aluOp !== 2'b10 || bus.aluSrc !== 1'b0) begin
                    $display("FAIL r_exec_alu: aluOp=%b aluSrc=%b, want 10/0", bus.aluOp, bus.aluSrc);
                    miscompares++;
                end
            end
            if (bus.pcWrite === 1'b1) pc_cnt++;
            step();
        end
        vectors++;
        if (pc_cnt != 1 || bus.instret !== start + 32'd1 || bus.state !== 3'd0) begin
            $display("FAIL r_retire: pcWrites=%0d instret=%0h state=%0d, want 1/%0h/0",
                     pc_cnt, bus.instret, bus.state, start + 32'd1);
            miscompares++;
        end
    endtask

    task automatic test_i_store();
        logic [31:0] start;
        drive(OP_I, 3'b000, 1'b0, 1'b1, 1'b0);
        start = bus.instret;
        step();
        step();
        vectors++;
        if (bus.state !== 3'd2 || bus.aluOp !== 2'b11 || bus.aluSrc !== 1'b1 || bus.pcWrite !== 1'b0) begin
            $display("FAIL i_exec: state=%0d aluOp=%b aluSrc=%b pcWrite=%b, want 2/11/1/0",
                     bus.state, bus.aluOp, bus.aluSrc, bus.pcWrite);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.state !== 3'd4 || bus.regwrite !== 1'b1 || bus.memtoReg !== 1'b0 || bus.pcWrite !== 1'b1) begin
            $display("FAIL i_wb: state=%0d regwrite=%b memtoReg=%b pcWrite=%b, want 4/1/0/1",
                     bus.state, bus.regwrite, bus.memtoReg, bus.pcWrite);
            miscompares++;
        end
        step();
        drive(OP_STORE, 3'b010, 1'b0, 1'b1, 1'b1);
        step();
        step();
        vectors++;
        if (bus.state !== 3'd2 || bus.aluOp !== 2'b00 || bus.aluSrc !== 1'b1) begin
            $display("FAIL st_exec: state=%0d aluOp=%b aluSrc=%b, want 2/00/1", bus.state, bus.aluOp, bus.aluSrc);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.state !== 3'd3 || bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 ||
            bus.pcWrite !== 1'b1 || bus.pcSrc !== 1'b0 || bus.regwrite !== 1'b0) begin
            $display("FAIL st_mem: state=%0d memWrite=%b memRead=%b pcWrite=%b pcSrc=%b regwrite=%b, want 3/1/0/1/0/0",
                     bus.state, bus.memWrite, bus.memRead, bus.pcWrite, bus.pcSrc, bus.regwrite);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.state !== 3'd0 || bus.instret !== start + 32'd2) begin
            $display("FAIL st_retire: state=%0d instret=%0h, want 0/%0h", bus.state, bus.instret, start + 32'd2);
            miscompares++;
        end
    endtask

    task automatic test_load_wait();
        logic [31:0] start;
        logic [2:0]  exp_st;
        int          rd_cnt;
        drive(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0);
        start  = bus.instret;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.dmemReady = (i == 6);
            #1;
            exp_st = (i < 3) ? i[2:0] : (i < 7) ? 3'd3 : 3'd4;
            vectors++;
            if (bus.state !== exp_st || bus.memRead !== (i >= 3 && i <= 6) ||
                bus.pcWrite !== (i == 7) || bus.memtoReg !== (i == 7) || bus.regwrite !== (i == 7)) begin
                $display("FAIL ld_cycle%0d: state=%0d memRead=%b pcWrite=%b memtoReg=%b regwrite=%b, want %0d/%b/%b/%b/%b",
                         i, bus.state, bus.memRead, bus.pcWrite, bus.memtoReg, bus.regwrite,
                         exp_st, (i >= 3 && i <= 6), (i == 7), (i == 7), (i == 7));
                miscompares++;
            end
            if (bus.memRead === 1'b1) rd_cnt++;
            step();
        end
        vectors++;
        if (rd_cnt != 4 || bus.state !== 3'd0 || bus.instret !== start + 32'd1) begin
            $display("FAIL ld_total: memRead cycles=%0d state=%0d instret=%0h, want 4/0/%0h",
                     rd_cnt, bus.state, bus.instret, start + 32'd1);
            miscompares++;
        end
        bus.dmemReady = 1'b0;
    endtask

    task automatic test_branch();
        logic [2:0]  f3_tab [4];
        logic        z_tab  [4];
        logic        src_tab[4];
        logic [31:0] start;
        f3_tab[0] = 3'b000; z_tab[0] = 1'b1; src_tab[0] = 1'b1;
        f3_tab[1] = 3'b001; z_tab[1] = 1'b1; src_tab[1] = 1'b0;
        f3_tab[2] = 3'b000; z_tab[2] = 1'b0; src_tab[2] = 1'b0;
        f3_tab[3] = 3'b001; z_tab[3] = 1'b0; src_tab[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(OP_BRANCH, f3_tab[k], z_tab[k], 1'b1, 1'b0);
            start = bus.instret;
            step();
            step();
            vectors++;
            if (bus.state !== 3'd2 || bus.pcWrite !== 1'b1 || bus.pcSrc !== src_tab[k] || bus.aluOp !== 2'b01) begin
                $display("FAIL br%0d_exec: state=%0d pcWrite=%b pcSrc=%b aluOp=%b, want 2/1/%b/01",
                         k, bus.state, bus.pcWrite, bus.pcSrc, bus.aluOp, src_tab[k]);
                miscompares++;
            end
            step();
            vectors++;
            if (bus.state !== 3'd0 || bus.instret !== start + 32'd1) begin
                $display("FAIL br%0d_retire: state=%0d instret=%0h, want 0/%0h",
                         k, bus.state, bus.instret, start + 32'd1);
                miscompares++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  op_tab [2];
        logic [2:0]  f3_tab [2];
        logic [31:0] start;
        op_tab[0] = 7'b1111111; f3_tab[0] = 3'b000;
        op_tab[1] = OP_BRANCH;  f3_tab[1] = 3'b010;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            drive(op_tab[k], f3_tab[k], 1'b0, 1'b1, 1'b1);
            start = bus.instret;
            step();
            vectors++;
            if (bus.state !== 3'd1 ||
                {bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite} !== 5'b0) begin
                $display("FAIL ill%0d_decode: state=%0d strobes=%b, want 1/00000", k, bus.state,
                         {bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite});
                miscompares++;
            end
            for (int c = 0; c < 3; c++) begin
                step();
                vectors++;
                if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.instret !== start ||
                    {bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite} !== 5'b0) begin
                    $display("FAIL ill%0d_halt%0d: state=%0d halted=%b instret=%0h strobes=%b, want 5/1/%0h/00000",
                             k, c, bus.state, bus.halted, bus.instret,
                             {bus.pcWrite, bus.irWrite, bus.regwrite, bus.memRead, bus.memWrite}, start);
                    miscompares++;
                end
            end
        end
        apply_reset();
        vectors++;
        if (bus.state !== 3'd0 || bus.halted !== 1'b0) begin
            $display("FAIL halt_exit: state=%0d halted=%b, want 0/0", bus.state, bus.halted);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_store();
        drive(OP_R, 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (4) step();
        drive(OP_STORE, 3'b010, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        step();
        vectors++;
        if (bus.state !== 3'd3 || bus.memWrite !== 1'b1 || bus.instret === 32'd0) begin
            $display("FAIL rst_st_pre: state=%0d memWrite=%b instret=%0h, want 3/1/nonzero",
                     bus.state, bus.memWrite, bus.instret);
            miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.memWrite !== 1'b0 || bus.pcWrite !== 1'b0) begin
            $display("FAIL rst_st_gate: memWrite=%b pcWrite=%b, want 0/0", bus.memWrite, bus.pcWrite);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.state !== 3'd0 || bus.instret !== 32'd0) begin
            $display("FAIL rst_st_after: state=%0d instret=%0h, want 0/0", bus.state, bus.instret);
            miscompares++;
        end
        reset = 1'b0;
    endtask

    task automatic test_instret_wrap();
        drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        vectors++;
        if (bus.instret !== 32'hFFFF_FFFF || bus.state !== 3'd0) begin
            $display("FAIL wrap_preload: instret=%0h state=%0d, want ffffffff/0", bus.instret, bus.state);
            miscompares++;
        end
        bus.imemReady = 1'b1;
        repeat (4) step();
        vectors++;
        if (bus.instret !== 32'd0 || bus.state !== 3'd0) begin
            $display("FAIL wrap_retire: instret=%0h state=%0d, want 0/0", bus.instret, bus.state);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_r_type();
        test_i_store();
        test_load_wait();
        test_branch();
        test_illegal();
        test_reset_mid_store();
        test_instret_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
